psum_recirculator: RTL and testbench
====================================

# psum_recirculator

Drains the CNN result buffer one word at a time and writes each word back into the psum buffer, so one pass's outputs become the next pass's partial sums without host involvement. It is the hardware counterpart of the host-side psum loader: it issues result reads on the result port and acts as the psum buffer's write initiator. It sits beside the CNN core on the same clock.

## Interface
- RESULT_BUFFER_WIDTH, 16, result word width
- PSUM_BUFFER_WIDTH, 16, psum word width; must equal RESULT_BUFFER_WIDTH (elaboration error otherwise)
- COUNT_WIDTH, 7, width of word_count/words_moved (≥ $clog2(RESULT_BUFFER_COLUMNS)+1)
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- start  in  1  one-cycle request to move word_count words
- word_count  in  COUNT_WIDTH  words to move, sampled with start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle completion pulse
- words_moved  out  COUNT_WIDTH  psum writes completed in current/last run
- result_buffer_out  in  RESULT_BUFFER_WIDTH  result data
- result_buffer_empty  in  1  result buffer holds no word
- result_buffer_valid  in  1  result_buffer_out valid for current read
- result_buffer_read_enable  out  1  read request
- psum_buffer_in  out  PSUM_BUFFER_WIDTH  write data, registered
- psum_buffer_wen  out  1  write request, registered
- psum_buffer_ready  in  1  psum buffer accepts write
- bias  in  PSUM_BUFFER_WIDTH  signed per-word offset (only with PSUM_RECIRC_BIAS_EN)

## Operation
- FSM states: IDLE, REQ, HOLD, GAP, DONE.
- IDLE: start=1 with word_count≠0 → latch count, clear words_moved, go REQ. word_count=0 → DONE directly (no read). start while not IDLE ignored.
- REQ: result_buffer_read_enable = !result_buffer_empty (combinational from state). On edge with read_enable && valid: capture result_buffer_out into data register, go HOLD. Empty → wait, no request.
- HOLD: psum_buffer_wen=1, psum_buffer_in = captured word. On edge with wen && ready: words_moved+1, remaining−1; remaining reaches 0 → DONE, else GAP. Data and wen held stable until transfer.
- GAP: one cycle, read_enable=0, wen=0 → REQ. Guarantees exactly one word per read request.
- DONE: done=1 for one cycle → IDLE.
- words_moved holds its final value in IDLE until the next accepted start.
- Data arithmetic: pass-through (see Configuration).

## Timing
- Reset values: busy=0, done=0, words_moved=0, result_buffer_read_enable=0, psum_buffer_wen=0, psum_buffer_in=0, state IDLE.
- start sampled at edge N → REQ during cycle N+1, read_enable high in N+1 if not empty.
- Minimum 3 cycles per word (REQ, HOLD, GAP) with valid and ready immediate; last word: REQ, HOLD, DONE.
- No timeouts; FSM waits indefinitely on valid or ready.
- Reset asserted mid-run: all outputs return to reset values at the next edge; an in-flight word is dropped without a write.
- valid high outside REQ is ignored; ready high outside HOLD is ignored.

## Configuration
- PSUM_RECIRC_BIAS_EN defined: bias port present; the word captured in REQ becomes sat(result + bias), signed two's-complement, saturating to [−2^(W−1), 2^(W−1)−1], computed at capture (no added latency).
- Undefined: bias port absent; psum_buffer_in equals the captured result word bit-for-bit.

## Structure
- Shared package cnn_pkg: FSM state enum typedef, default RESULT/PSUM buffer widths, COUNT_WIDTH default.
- Sub-module sat_add (W-bit signed saturating adder), instantiated only under PSUM_RECIRC_BIAS_EN.

## Test plan
- Reset: hold reset=0 for 3 cycles with start=1 → all outputs 0, busy never rises.
- Basic: 4 words 0x0001..0x0004, valid and ready immediate, word_count=4 → four writes in order, one every 3 cycles, done pulse, words_moved=4.
- Backpressure: ready low 5 cycles in HOLD → wen and data stable throughout, single write when ready rises.
- Empty stall: result_buffer_empty=1 for 10 cycles in REQ → read_enable 0 throughout; first read in the cycle empty falls.
- word_count=0 and start while busy → done one cycle after start, no read; second start ignored, words_moved unchanged.
- Bias (macro on): result 0x7FF0, bias 0x0020 → write 0x7FFF; result 0x8005, bias 0xFFF0 → write 0x8000.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN definitions: default buffer widths and the psum recirculator FSM states.
package cnn_pkg;

  localparam int RESULT_BUFFER_WIDTH_DEF = 16;
  localparam int PSUM_BUFFER_WIDTH_DEF   = 16;
  localparam int COUNT_WIDTH_DEF         = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_GAP,
    ST_DONE
  } recirc_state_t;

endpackage

// File: rtl/psum_recirculator_sat_add.sv
// W-bit signed two's-complement adder that clamps to the representable range.
module sat_add #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);

  function automatic logic signed [W-1:0] sat_sum(input logic signed [W:0] s);
    // Sign bits disagree only when the true sum left the W-bit range.
    if (s[W] != s[W-1]) begin
      return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
    return s[W-1:0];
  endfunction

  always_comb begin
    y = sat_sum({a[W-1], a} + {b[W-1], b});
  end

endmodule

// File: rtl/psum_recirculator.sv
// Moves result-buffer words into the psum buffer, one read per write.
// Optional PSUM_RECIRC_BIAS_EN adds a saturating signed bias to every captured word.
module psum_recirculator
  import cnn_pkg::*;
#(
  parameter int RESULT_BUFFER_WIDTH = RESULT_BUFFER_WIDTH_DEF,
  parameter int PSUM_BUFFER_WIDTH   = PSUM_BUFFER_WIDTH_DEF,
  parameter int COUNT_WIDTH         = COUNT_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [COUNT_WIDTH-1:0]         word_count,
  output logic                           busy,
  output logic                           done,
  output logic [COUNT_WIDTH-1:0]         words_moved,
  input  logic [RESULT_BUFFER_WIDTH-1:0] result_buffer_out,
  input  logic                           result_buffer_empty,
  input  logic                           result_buffer_valid,
  output logic                           result_buffer_read_enable,
  output logic [PSUM_BUFFER_WIDTH-1:0]   psum_buffer_in,
  output logic                           psum_buffer_wen,
  input  logic                           psum_buffer_ready
`ifdef PSUM_RECIRC_BIAS_EN
  ,
  input  logic signed [PSUM_BUFFER_WIDTH-1:0] bias
`endif
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  if (PSUM_BUFFER_WIDTH != RESULT_BUFFER_WIDTH) begin : g_width_check
    $error("psum_recirculator: PSUM_BUFFER_WIDTH must equal RESULT_BUFFER_WIDTH");
  end

  recirc_state_t                state, state_nxt;
  logic [COUNT_WIDTH-1:0]       remaining;
  logic [PSUM_BUFFER_WIDTH-1:0] capture_word;
  logic                         rd_fire;
  logic                         wr_fire;

`ifdef PSUM_RECIRC_BIAS_EN
  logic signed [PSUM_BUFFER_WIDTH-1:0] biased_word;

  sat_add #(.W(PSUM_BUFFER_WIDTH)) u_sat_add (
    .a (result_buffer_out),
    .b (bias),
    .y (biased_word)
  );

  assign capture_word = biased_word;
`else
  assign capture_word = result_buffer_out;
`endif

  assign result_buffer_read_enable = (state == ST_REQ) && !result_buffer_empty;
  assign psum_buffer_wen           = (state == ST_HOLD);
  assign busy                      = (state != ST_IDLE);
  assign done                      = (state == ST_DONE);
  assign rd_fire                   = result_buffer_read_enable && result_buffer_valid;
  assign wr_fire                   = psum_buffer_wen && psum_buffer_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start) state_nxt = (word_count == '0) ? ST_DONE : ST_REQ;
      ST_REQ:  if (rd_fire) state_nxt = ST_HOLD;
      ST_HOLD: if (wr_fire) state_nxt = (remaining == CNT_ONE) ? ST_DONE : ST_GAP;
      // GAP forces a fresh request so each read yields exactly one word.
      ST_GAP:  state_nxt = ST_REQ;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= ST_IDLE;
      remaining      <= '0;
      words_moved    <= '0;
      psum_buffer_in <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start && word_count != '0) begin
        remaining   <= word_count;
        words_moved <= '0;
      end
      if (rd_fire) psum_buffer_in <= capture_word;
      if (wr_fire) begin
        remaining   <= remaining - CNT_ONE;
        words_moved <= words_moved + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_psum_recirculator.sv
// Directed bench for psum_recirculator with a cycle-level behavioural scoreboard.
module tb_psum_recirculator;

  localparam int W  = 16;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] word_count;
  logic          busy, done;
  logic [CW-1:0] words_moved;
  logic [W-1:0]  result_buffer_out;
  logic          result_buffer_empty, result_buffer_valid, result_buffer_read_enable;
  logic [W-1:0]  psum_buffer_in;
  logic          psum_buffer_wen, psum_buffer_ready;
`ifdef PSUM_RECIRC_BIAS_EN
  logic [W-1:0]  bias;
`endif

  always #5 clk = ~clk;

  psum_recirculator dut (
    .clk                       (clk),
    .reset                     (reset),
    .start                     (start),
    .word_count                (word_count),
    .busy                      (busy),
    .done                      (done),
    .words_moved               (words_moved),
    .result_buffer_out         (result_buffer_out),
    .result_buffer_empty       (result_buffer_empty),
    .result_buffer_valid       (result_buffer_valid),
    .result_buffer_read_enable (result_buffer_read_enable),
    .psum_buffer_in            (psum_buffer_in),
    .psum_buffer_wen           (psum_buffer_wen),
    .psum_buffer_ready         (psum_buffer_ready)
`ifdef PSUM_RECIRC_BIAS_EN
    ,
    .bias                      (bias)
`endif
  );

  // Result-buffer source: a word list with a read pointer, valid on the request cycle.
  logic [W-1:0] mem [0:15];
  int           src_len = 0;
  int           rd_idx = 0;
  logic         force_empty = 1'b0;
  assign result_buffer_empty = force_empty || (rd_idx >= src_len);
  assign result_buffer_out   = mem[rd_idx[3:0]];
  assign result_buffer_valid = result_buffer_read_enable;

  logic [W-1:0] expw [0:15];
  logic [W-1:0] wlog [0:15];
  int           wcyc [0:15];
  int           rcyc [0:15];
  int           wr_idx = 0, n_rd = 0, n_done = 0, done_cyc = 0, cyc = 0;
  int           total = 0, bad = 0;

  function automatic logic [W-1:0] model_word(input logic [W-1:0] r);
`ifdef PSUM_RECIRC_BIAS_EN
    int s;
    s = int'($signed(r)) + int'($signed(bias));
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s[W-1:0];
`else
    return r;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard: tracks run activity, expected done timing and words_moved from transfer counts.
  bit           rst_prev = 1'b1, run_active = 1'b0, done_due = 1'b0, hold_prev = 1'b0, pop_pend = 1'b0;
  bit           nd, acc;
  int           mv_cnt = 0, remaining = 0;
  logic [W-1:0] data_prev = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (pop_pend) begin
        rd_idx++;
        pop_pend = 1'b0;
      end
      #1;
      cyc++;
      if (rst_prev) begin
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_words_moved", 32'(words_moved), 0);
        chk("rst_read_enable", 32'(result_buffer_read_enable), 0);
        chk("rst_wen", 32'(psum_buffer_wen), 0);
        chk("rst_psum_in", 32'(psum_buffer_in), 0);
        run_active = 1'b0;
        done_due   = 1'b0;
        mv_cnt     = 0;
        hold_prev  = 1'b0;
      end else begin
        chk("busy", 32'(busy), 32'(run_active));
        chk("done", 32'(done), 32'(done_due));
        chk("words_moved", 32'(words_moved), 32'(mv_cnt));
        chk("read_while_empty", 32'(result_buffer_read_enable & result_buffer_empty), 0);
        chk("read_outside_run", 32'(result_buffer_read_enable & ~run_active), 0);
        if (hold_prev) begin
          chk("hold_wen", 32'(psum_buffer_wen), 1);
          chk("hold_data", 32'(psum_buffer_in), 32'(data_prev));
        end
        if (done) begin
          n_done++;
          done_cyc = cyc;
        end
        if (result_buffer_read_enable && result_buffer_valid) begin
          rcyc[n_rd % 16] = cyc;
          n_rd++;
          pop_pend = 1'b1;
        end
        nd = 1'b0;
        if (psum_buffer_wen && psum_buffer_ready && reset) begin
          chk("write_data", 32'(psum_buffer_in), 32'(expw[wr_idx % 16]));
          wlog[wr_idx % 16] = psum_buffer_in;
          wcyc[wr_idx % 16] = cyc;
          wr_idx++;
          mv_cnt++;
          remaining--;
          if (remaining == 0) nd = 1'b1;
        end
        hold_prev = psum_buffer_wen && !psum_buffer_ready && reset;
        data_prev = psum_buffer_in;
        acc = reset && start && !run_active;
        if (done_due) run_active = 1'b0;
        done_due = nd;
        if (acc) begin
          run_active = 1'b1;
          remaining  = int'(word_count);
          if (word_count != '0) mv_cnt = 0;
          else done_due = 1'b1;
        end
      end
      rst_prev = !reset;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  int start_cyc, r0, d0, rel;

  task automatic prep(input int n);
    src_len = n;
    rd_idx  = 0;
    wr_idx  = 0;
    for (int i = 0; i < n; i++) expw[i] = model_word(mem[i]);
  endtask

  task automatic run(input int cnt);
    @(negedge clk);
    start      = 1'b1;
    word_count = CW'(cnt);
    #2 start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int d;
    bit seen;
    d = n_done;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      #2;
      if (n_done != d) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_wen(input int maxc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      #2;
      if (psum_buffer_wen) seen = 1'b1;
    end
    if (!seen) chk("wen_timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b1;
    word_count = CW'(4);
    psum_buffer_ready = 1'b1;
`ifdef PSUM_RECIRC_BIAS_EN
    bias = '0;
`endif
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset held with start asserted
    repeat (3) @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    #2 chk("reset_no_reads", 32'(n_rd), 0);

    // Basic four-word transfer
    for (int i = 0; i < 4; i++) mem[i] = W'(i + 1);
    prep(4);
    r0 = n_rd;
    run(4);
    wait_done(40);
    chk("basic_w0", 32'(wlog[0]), 32'h0001);
    chk("basic_w1", 32'(wlog[1]), 32'h0002);
    chk("basic_w2", 32'(wlog[2]), 32'h0003);
    chk("basic_w3", 32'(wlog[3]), 32'h0004);
    chk("basic_first_read", 32'(rcyc[r0 % 16]), 32'(start_cyc + 1));
    chk("basic_first_write", 32'(wcyc[0]), 32'(start_cyc + 2));
    chk("basic_spacing1", 32'(wcyc[1] - wcyc[0]), 3);
    chk("basic_spacing3", 32'(wcyc[3] - wcyc[2]), 3);
    chk("basic_done_cycle", 32'(done_cyc), 32'(wcyc[3] + 1));
    chk("basic_reads", 32'(n_rd - r0), 4);
    @(negedge clk);
    #2 chk("basic_words_moved", 32'(words_moved), 4);

    // Backpressure in HOLD
    mem[0] = 16'h00A5;
    prep(1);
    psum_buffer_ready = 1'b0;
    run(1);
    wait_wen(20);
    repeat (5) @(negedge clk);
    chk("bp_no_write", 32'(wr_idx), 0);
    psum_buffer_ready = 1'b1;
    wait_done(20);
    chk("bp_one_write", 32'(wr_idx), 1);
    chk("bp_data", 32'(wlog[0]), 32'h00A5);

    // Empty stall in REQ
    mem[0] = 16'h1234;
    mem[1] = 16'h5678;
    prep(2);
    force_empty = 1'b1;
    r0 = n_rd;
    run(2);
    repeat (10) @(negedge clk);
    chk("stall_no_read", 32'(n_rd - r0), 0);
    force_empty = 1'b0;
    #2 rel = cyc;
    wait_done(30);
    chk("stall_first_read", 32'(rcyc[r0 % 16]), 32'(rel));
    chk("stall_w0", 32'(wlog[0]), 32'h1234);
    chk("stall_w1", 32'(wlog[1]), 32'h5678);

    // Zero-length request
    prep(0);
    r0 = n_rd;
    run(0);
    wait_done(5);
    chk("zero_done_cycle", 32'(done_cyc), 32'(start_cyc + 1));
    chk("zero_no_read", 32'(n_rd - r0), 0);
    chk("zero_words_moved", 32'(words_moved), 2);

    // Start while busy is ignored
    mem[0] = 16'h0011;
    mem[1] = 16'h0022;
    prep(2);
    d0 = n_done;
    run(2);
    run(9);
    wait_done(30);
    repeat (3) @(negedge clk);
    #2;
    chk("busy_start_words_moved", 32'(words_moved), 2);
    chk("busy_start_writes", 32'(wr_idx), 2);
    chk("busy_start_done_count", 32'(n_done - d0), 1);
    chk("busy_start_idle", 32'(busy), 0);

    // Reset during HOLD drops the in-flight word
    mem[0] = 16'h0BAD;
    mem[1] = 16'h0C0D;
    prep(2);
    psum_buffer_ready = 1'b0;
    run(2);
    wait_wen(20);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #2;
    chk("midrst_no_write", 32'(wr_idx), 0);
    chk("midrst_wen", 32'(psum_buffer_wen), 0);
    psum_buffer_ready = 1'b1;
    mem[0] = 16'h0777;
    prep(1);
    run(1);
    wait_done(20);
    chk("midrst_recover", 32'(wlog[0]), 32'h0777);

`ifdef PSUM_RECIRC_BIAS_EN
    // Saturating bias
    bias = 16'h0020;
    mem[0] = 16'h7FF0;
    prep(1);
    run(1);
    wait_done(20);
    chk("bias_pos_sat", 32'(wlog[0]), 32'h7FFF);
    bias = 16'hFFF0;
    mem[0] = 16'h8005;
    prep(1);
    run(1);
    wait_done(20);
    chk("bias_neg_sat", 32'(wlog[0]), 32'h8000);
    bias = 16'h0003;
    mem[0] = 16'h0100;
    prep(1);
    run(1);
    wait_done(20);
    chk("bias_plain", 32'(wlog[0]), 32'h0103);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
